// File: rtl/reg_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_pkg                                                 |
// | Description : Shared constants and address-qualification helper for the   |
// |               parametrised CPU register bank.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package reg_file_pkg;

  // Default geometry matches the original 4x8 register bank.
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_ADDR_W  = 2;
  localparam int unsigned DEF_NREGS   = 4;
  localparam int unsigned DEF_TAP_REG = 2;
  localparam int unsigned DEF_ZERO_R0 = 1;

  // Index of the optional hard-wired zero register.
  localparam int unsigned ZERO_IDX = 0;

  // True when an address refers to real, modifiable storage. The same test
  // decides whether a write lands and whether a read may return non-zero
  // data (including forwarded write data), so both sides stay consistent.
  function automatic logic addr_writable(input int unsigned addr,
                                         input int unsigned nregs,
                                         input int unsigned zero_r0);
    logic in_range;
    logic is_zero_reg;
    in_range    = (addr < nregs);
    is_zero_reg = (zero_r0 != 0) && (addr == ZERO_IDX);
    return in_range && !is_zero_reg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_read_port                                           |
// | Description : One registered read port of the register bank: address      |
// |               qualification, optional write-through forwarding and the     |
// |               rd_en-gated output register.                                 |
// |               Build option: REG_FILE_BYPASS_EN enables forwarding of the    |
// |               same-edge write data to this port.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned ZERO_R0 = DEF_ZERO_R0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [NREGS*DATA_W-1:0] rf_flat,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       rd_data
);

  logic              w_readable;
  logic [DATA_W-1:0] w_stored;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Out-of-range and zero-register addresses always read as zero.
  assign w_readable = addr_writable(32'(rd_addr), NREGS, ZERO_R0);

  // Select the stored value; the compare loop avoids indexing past NREGS.
  always_comb begin
    w_stored = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (32'(rd_addr) == i) begin
        w_stored = rf_flat[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic w_fwd;

  // A write landing on this edge to the same address is forwarded.
  assign w_fwd = wr_en && (wr_addr == rd_addr);

  // Choose between zero, forwarded write data and stored data.
  always_comb begin
    w_sel = '0;
    if (w_readable) begin
      w_sel = w_fwd ? wr_data : w_stored;
    end
  end
`else
  // Write port is not consulted when forwarding is compiled out.
  logic w_unused_wr;
  assign w_unused_wr = ^{wr_en, wr_addr, wr_data};

  // Choose between zero and stored data (old value on a same-edge write).
  always_comb begin
    w_sel = '0;
    if (w_readable) begin
      w_sel = w_stored;
    end
  end
`endif

  // Capture on rd_en, otherwise hold the previous read result.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = w_sel;
    end
  end

  // Output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_bank                                                |
// | Description : NREGS x DATA_W register bank with one write port, two        |
// |               registered read ports (rd_en / rd_valid), a registered tap   |
// |               of register TAP_REG and a written-since-reset mask.          |
// |               Build option: REG_FILE_BYPASS_EN forwards same-edge write    |
// |               data to the read ports (the tap is never forwarded).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned TAP_REG = DEF_TAP_REG,
  parameter int unsigned ZERO_R0 = DEF_ZERO_R0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic [NREGS-1:0]  written_mask
);

  logic [DATA_W-1:0]       rf_q [NREGS];
  logic [DATA_W-1:0]       rf_d [NREGS];
  logic [NREGS-1:0]        mask_q;
  logic [NREGS-1:0]        mask_d;
  logic [DATA_W-1:0]       tap_q;
  logic [DATA_W-1:0]       tap_d;
  logic                    rd_valid_q;
  logic                    rd_valid_d;
  logic                    w_wr_ok;
  logic [NREGS*DATA_W-1:0] w_rf_flat;

  // A write lands only on real, modifiable storage.
  assign w_wr_ok = wr_en && addr_writable(32'(wr_addr), NREGS, ZERO_R0);

  // Next-state of storage and written mask from the write port.
  always_comb begin
    rf_d   = rf_q;
    mask_d = mask_q;
    if (w_wr_ok) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (32'(wr_addr) == i) begin
          rf_d[i]   = wr_data;
          mask_d[i] = 1'b1;
        end
      end
    end
  end

  // Tap mirrors the pre-write contents; valid follows rd_en by one edge.
  always_comb begin
    tap_d      = rf_q[TAP_REG];
    rd_valid_d = rd_en;
  end

  // Storage, mask, tap and valid registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      mask_q     <= '0;
      tap_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      mask_q     <= mask_d;
      tap_q      <= tap_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Flatten storage for the read-port sub-modules.
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign w_rf_flat[g*DATA_W +: DATA_W] = rf_q[g];
  end

  reg_file_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0)
  ) u_rd_port1 (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr1),
    .rf_flat (w_rf_flat),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data1)
  );

  reg_file_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0)
  ) u_rd_port2 (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr2),
    .rf_flat (w_rf_flat),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data2)
  );

  assign rd_valid     = rd_valid_q;
  assign tap_data     = tap_q;
  assign written_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_file_bank                                             |
// | Description : Self-checking bench for reg_file_bank. Three instances:      |
// |               A default (4x8, zero R0), B (3x8, ordinary R0) sharing A's   |
// |               inputs, C (8x16, tap on R7). Expectations follow             |
// |               REG_FILE_BYPASS_EN when it is defined.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_file_bank;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for instances A and B
  logic       we, re;
  logic [1:0] wa, ra1, ra2;
  logic [7:0] wd;

  logic [7:0] a_rd1, a_rd2, a_tap;
  logic       a_vld;
  logic [3:0] a_mask;
  logic [7:0] b_rd1, b_rd2, b_tap;
  logic       b_vld;
  logic [2:0] b_mask;

  // Stimulus and outputs for instance C
  logic        c_we, c_re;
  logic [2:0]  c_wa, c_ra1, c_ra2;
  logic [15:0] c_wd, c_rd1, c_rd2, c_tap;
  logic        c_vld;
  logic [7:0]  c_mask;

  reg_file_bank u_dut_a (
    .clock(clk), .reset(rst_n), .rd_addr1(ra1), .rd_addr2(ra2), .rd_en(re),
    .wr_addr(wa), .wr_data(wd), .wr_en(we), .rd_data1(a_rd1), .rd_data2(a_rd2),
    .rd_valid(a_vld), .tap_data(a_tap), .written_mask(a_mask)
  );

  reg_file_bank #(.DATA_W(8), .ADDR_W(2), .NREGS(3), .TAP_REG(2), .ZERO_R0(0)) u_dut_b (
    .clock(clk), .reset(rst_n), .rd_addr1(ra1), .rd_addr2(ra2), .rd_en(re),
    .wr_addr(wa), .wr_data(wd), .wr_en(we), .rd_data1(b_rd1), .rd_data2(b_rd2),
    .rd_valid(b_vld), .tap_data(b_tap), .written_mask(b_mask)
  );

  reg_file_bank #(.DATA_W(16), .ADDR_W(3), .NREGS(8), .TAP_REG(7), .ZERO_R0(1)) u_dut_c (
    .clock(clk), .reset(rst_n), .rd_addr1(c_ra1), .rd_addr2(c_ra2), .rd_en(c_re),
    .wr_addr(c_wa), .wr_data(c_wd), .wr_en(c_we), .rd_data1(c_rd1), .rd_data2(c_rd2),
    .rd_valid(c_vld), .tap_data(c_tap), .written_mask(c_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [1:0] ra1, ra2;
    logic [7:0] a1, a2, b1, b2;
    logic       vld;
    logic [7:0] tap;
    logic [3:0] ma;
    logic [2:0] mb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we_i, input logic [1:0] wa_i, input logic [7:0] wd_i,
                     input logic re_i, input logic [1:0] ra1_i, input logic [1:0] ra2_i,
                     input logic [7:0] a1, input logic [7:0] a2,
                     input logic [7:0] b1, input logic [7:0] b2,
                     input logic vld, input logic [7:0] tap,
                     input logic [3:0] ma, input logic [2:0] mb);
    vec_t v;
    v.we = we_i; v.wa = wa_i; v.wd = wd_i; v.re = re_i; v.ra1 = ra1_i; v.ra2 = ra2_i;
    v.a1 = a1; v.a2 = a2; v.b1 = b1; v.b2 = b2;
    v.vld = vld; v.tap = tap; v.ma = ma; v.mb = mb;
    vecs.push_back(v);
  endtask

  // Watchdog: the bench has no open-ended waits, but never let it hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] hz;   // same-edge read of R2 while writing 0x77 over 0x11
    logic [7:0] hb;   // same-edge read of R0 on B while writing 0xEE over 0xFF
    logic [7:0] h3;   // same-edge read of R3 on A while writing 0xC3 over 0x99
    hz = BYP ? 8'h77 : 8'h11;
    hb = BYP ? 8'hEE : 8'hFF;
    h3 = BYP ? 8'hC3 : 8'h99;

    //   we wa  wd    re ra1 ra2  A1     A2     B1     B2    vld tap    mA    mB
    add(1, 1, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 4'h2, 3'h2);
    add(1, 3, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 4'hA, 3'h2);
    add(0, 0, 8'h00, 1, 1, 3, 8'hA5, 8'h3C, 8'hA5, 8'h00, 1, 8'h00, 4'hA, 3'h2);
    add(1, 0, 8'hFF, 0, 1, 3, 8'hA5, 8'h3C, 8'hA5, 8'h00, 0, 8'h00, 4'hA, 3'h3);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1, 8'h00, 4'hA, 3'h3);
    add(1, 2, 8'h11, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4'hE, 3'h7);
    add(1, 2, 8'h77, 1, 2, 2, hz,    hz,    hz,    hz,    1, 8'h11, 4'hE, 3'h7);
    add(0, 0, 8'h00, 0, 2, 2, hz,    hz,    hz,    hz,    0, 8'h77, 4'hE, 3'h7);
    add(0, 0, 8'h00, 1, 2, 3, 8'h77, 8'h3C, 8'h77, 8'h00, 1, 8'h77, 4'hE, 3'h7);
    add(1, 3, 8'h99, 0, 1, 1, 8'h77, 8'h3C, 8'h77, 8'h00, 0, 8'h77, 4'hE, 3'h7);
    add(0, 0, 8'h00, 0, 0, 2, 8'h77, 8'h3C, 8'h77, 8'h00, 0, 8'h77, 4'hE, 3'h7);
    add(1, 1, 8'h5A, 0, 3, 3, 8'h77, 8'h3C, 8'h77, 8'h00, 0, 8'h77, 4'hE, 3'h7);
    add(0, 0, 8'h00, 0, 2, 0, 8'h77, 8'h3C, 8'h77, 8'h00, 0, 8'h77, 4'hE, 3'h7);
    add(0, 0, 8'h00, 1, 3, 1, 8'h99, 8'h5A, 8'h00, 8'h5A, 1, 8'h77, 4'hE, 3'h7);
    add(1, 0, 8'hEE, 1, 0, 0, 8'h00, 8'h00, hb,    hb,    1, 8'h77, 4'hE, 3'h7);
    add(0, 0, 8'h00, 1, 0, 1, 8'h00, 8'h5A, 8'hEE, 8'h5A, 1, 8'h77, 4'hE, 3'h7);
    add(1, 3, 8'hC3, 1, 3, 3, h3,    h3,    8'h00, 8'h00, 1, 8'h77, 4'hE, 3'h7);
    add(0, 0, 8'h00, 1, 3, 2, 8'hC3, 8'h77, 8'h00, 8'h77, 1, 8'h77, 4'hE, 3'h7);

    // Power-on reset
    rst_n = 1'b0;
    we = 0; wa = 0; wd = 0; re = 0; ra1 = 0; ra2 = 0;
    c_we = 0; c_wa = 0; c_wd = 0; c_re = 0; c_ra1 = 0; c_ra2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("por a_rd1",  16'(a_rd1), 16'h0);
    chk("por a_vld",  16'(a_vld), 16'h0);
    chk("por a_mask", 16'(a_mask), 16'h0);
    chk("por c_mask", 16'(c_mask), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequence on instances A and B
    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      re = vecs[i].re; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d a_rd1", i),  16'(a_rd1),  16'(vecs[i].a1));
      chk($sformatf("v%0d a_rd2", i),  16'(a_rd2),  16'(vecs[i].a2));
      chk($sformatf("v%0d b_rd1", i),  16'(b_rd1),  16'(vecs[i].b1));
      chk($sformatf("v%0d b_rd2", i),  16'(b_rd2),  16'(vecs[i].b2));
      chk($sformatf("v%0d a_vld", i),  16'(a_vld),  16'(vecs[i].vld));
      chk($sformatf("v%0d b_vld", i),  16'(b_vld),  16'(vecs[i].vld));
      chk($sformatf("v%0d a_tap", i),  16'(a_tap),  16'(vecs[i].tap));
      chk($sformatf("v%0d b_tap", i),  16'(b_tap),  16'(vecs[i].tap));
      chk($sformatf("v%0d a_mask", i), 16'(a_mask), 16'(vecs[i].ma));
      chk($sformatf("v%0d b_mask", i), 16'(b_mask), 16'(vecs[i].mb));
    end

    // Wide instance: R7 = 0xBEEF read on both ports, tap on R7
    c_we = 1; c_wa = 3'd7; c_wd = 16'hBEEF;
    @(posedge clk);
    #1;
    c_we = 0; c_re = 1; c_ra1 = 3'd7; c_ra2 = 3'd7;
    @(posedge clk);
    #1;
    chk("wide rd1",  c_rd1, 16'hBEEF);
    chk("wide rd2",  c_rd2, 16'hBEEF);
    chk("wide vld",  16'(c_vld), 16'h1);
    chk("wide mask", 16'(c_mask), 16'h0080);
    chk("wide tap",  c_tap, 16'hBEEF);
    c_re = 0;

    // Mid-cycle asynchronous reset with a write and read pending
    we = 1; wa = 2'd1; wd = 8'h42; re = 1; ra1 = 2'd2; ra2 = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst a_rd1",  16'(a_rd1),  16'h0);
    chk("arst a_rd2",  16'(a_rd2),  16'h0);
    chk("arst a_vld",  16'(a_vld),  16'h0);
    chk("arst a_tap",  16'(a_tap),  16'h0);
    chk("arst a_mask", 16'(a_mask), 16'h0);
    chk("arst b_rd1",  16'(b_rd1),  16'h0);
    chk("arst b_mask", 16'(b_mask), 16'h0);
    chk("arst c_rd1",  c_rd1,       16'h0);
    chk("arst c_mask", 16'(c_mask), 16'h0);
    @(posedge clk);
    @(negedge clk);
    we = 0; re = 0;
    rst_n = 1'b1;

    // Reads after release return zero and nothing is marked written
    re = 1; ra1 = 2'd1; ra2 = 2'd3;
    @(posedge clk);
    #1;
    chk("post a_rd1",  16'(a_rd1),  16'h0);
    chk("post a_rd2",  16'(a_rd2),  16'h0);
    chk("post a_vld",  16'(a_vld),  16'h1);
    chk("post b_rd1",  16'(b_rd1),  16'h0);
    chk("post a_mask", 16'(a_mask), 16'h0);
    chk("post b_mask", 16'(b_mask), 16'h0);
    re = 0;
    @(posedge clk);
    #1;
    chk("post a_vld drop", 16'(a_vld), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
